audio_pwm_out: RTL

- Downstream consumer of the memory controller's mixed sample (`data_read`, track1+track2).
- Buffers incoming 16-bit samples in a small FIFO, applies shift-based volume and mute, and drives a single-bit PWM audio pin.
- Double-buffers duty so samples change only on PWM period boundaries.
- Decouples the controller's sample strobe from the PWM period and reports overflow/underrun.

---
 rtl/audio_pwm_out.sv | 107 ++++++++++
 1 files changed

// File: rtl/audio_pwm_out.sv
// PWM audio output stage: sample FIFO, shift-based volume, mute, and a
// boundary-synchronised duty register driving a single-bit PWM pin.
module audio_pwm_out #(
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [15:0]                sample_in,
    input  logic                       sample_valid,
    input  logic [2:0]                 vol,
    input  logic                       mute,
    input  logic                       clear_flags,
    output logic                       pwm_out,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       overflow,
    output logic                       underrun
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [PWM_BITS-1:0] r_cnt;
    logic [PWM_BITS-1:0] r_duty;
    logic                r_pwm;
    logic [15:0]         r_mem [DEPTH];
    logic [AW-1:0]       r_wptr;
    logic [AW-1:0]       r_rptr;
    logic [LW-1:0]       r_level;
    logic                r_overflow;
    logic                r_underrun;

    logic                w_boundary;
    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic                w_push;
    logic                w_ovf_set;
    logic                w_unr_set;
    logic [15:0]         w_atten;

    always_comb begin
        w_boundary = &r_cnt;
        w_full     = (r_level == LW'(DEPTH));
        w_empty    = (r_level == '0);
        w_pop      = w_boundary & ~w_empty;
        // A pop on the same edge frees a slot, so a full FIFO still accepts.
        w_push     = sample_valid & (~w_full | w_pop);
        w_ovf_set  = sample_valid & w_full & ~w_pop;
        w_unr_set  = w_boundary & w_empty;
        w_atten    = r_mem[r_rptr] >> vol;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= sample_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_duty     <= '0;
            r_pwm      <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            r_pwm <= (r_cnt < r_duty) & ~mute;

            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
                r_duty <= w_atten[15 -: PWM_BITS];
            end

            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - 1'b1;
            end

            // Set events take priority over a coincident clear.
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (clear_flags) begin
                r_overflow <= 1'b0;
            end
            if (w_unr_set) begin
                r_underrun <= 1'b1;
            end else if (clear_flags) begin
                r_underrun <= 1'b0;
            end
        end
    end

    assign pwm_out    = r_pwm;
    assign fifo_level = r_level;
    assign overflow   = r_overflow;
    assign underrun   = r_underrun;

endmodule
